dma_fifo: RTL and testbench
===========================

# dma_fifo

Synchronous single-clock data buffer between the DMA fetch and deposit phases. It captures one word per `fifo_wr_en` pulse from `dma_fsm` and returns one word per `fifo_rd_en` pulse. It reports occupancy and full/empty/almost-full status. It optionally flags overflow and underflow errors for the bus-side controller.

## Interface
- `DATA_W`, 32: word width in bits.
- `DEPTH`, 16: number of entries. Must be a power of two, ≥ 2.
- `AF_THRESH`, 12: `almost_full` asserts when level ≥ this value. Range 1..DEPTH.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: write strobe; driven by `dma_fsm` `fifo_wr_en`.
- `wr_data`  in  DATA_W: write data, sampled when `wr_en`=1.
- `rd_en`  in  1: read strobe; driven by `dma_fsm` `fifo_rd_en`.
- `rd_data`  out  DATA_W: registered read data.
- `rd_valid`  out  1: one-cycle pulse marking `rd_data` as valid.
- `full`  out  1: level == DEPTH.
- `empty`  out  1: level == 0.
- `almost_full`  out  1: level ≥ AF_THRESH.
- `level`  out  $clog2(DEPTH)+1: current occupancy.
- `clr_err`  in  1: clears sticky error flags (present only with `DMA_FIFO_ERR_EN`).
- `overflow`  out  1: sticky; a write was attempted while full (present only with `DMA_FIFO_ERR_EN`).
- `underflow`  out  1: sticky; a read was attempted while empty (present only with `DMA_FIFO_ERR_EN`).

## Operation
- Storage: DEPTH×DATA_W register array.
- Pointers: `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits. They wrap naturally from DEPTH-1 to 0.
- `level` is a separate counter, $clog2(DEPTH)+1 bits wide.
- Accepted write = `wr_en & ~full`. Effect: `mem[wr_ptr]` <= `wr_data`, and `wr_ptr` increments.
- Accepted read = `rd_en & ~empty`. Effect: `rd_data` <= `mem[rd_ptr]`, `rd_ptr` increments, and `rd_valid`=1 on the next cycle.
- Full and empty are evaluated on pre-edge state.
- Simultaneous read and write:
  - Not empty and not full: both are accepted and level is unchanged.
  - Full: both are accepted, because the read frees a slot in the same edge. Level stays DEPTH.
  - Empty: only the write is accepted. The read is rejected and flags underflow. Level goes to 1. No same-cycle bypass.
- A rejected write or read leaves the pointers, level, memory and `rd_data` unchanged. `rd_valid` is 0 on the following cycle.
- `rd_data` holds its last value until the next accepted read.
- Status outputs `full`, `empty`, `almost_full` and `level` are combinational decodes of the registered level counter. They carry no extra latency.
- Reset values:
  - Pointers and level: 0.
  - `empty`: 1.
  - `full`, `almost_full`, `rd_valid`, `overflow`, `underflow`: 0.
  - `rd_data`: 0.
  - Memory contents: not reset.
- Reset mid-operation discards all contents immediately. The asynchronous assertion takes effect without a clock edge.

## Timing
- Write to visibility: a word written at edge N makes `empty`=0 after edge N. It can be read at edge N+1.
- Read latency is one cycle. With `rd_en` sampled at edge N, `rd_data`/`rd_valid` are valid after edge N and remain so until edge N+1.
- Throughput: one write and one read per cycle, sustained.
- The DMA FSM alternates write then read. Steady-state level therefore oscillates between 0 and 1 unless reads are suppressed.
- Reset release: the first accepted write is possible at the first rising edge after `rst` deasserts.

## Configuration
- `DMA_FIFO_ERR_EN` defined:
  - `overflow`, `underflow` and `clr_err` ports exist.
  - Each flag sets on its rejected access and holds until `clr_err`=1 at an edge, or reset.
  - If set and clear happen in the same cycle, set wins.
- `DMA_FIFO_ERR_EN` undefined:
  - Those three ports and their registers are absent.
  - Rejected accesses are silently dropped, with otherwise identical behaviour.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst`=1 mid-cycle, then release.
  - Required: `empty`=1, `level`=0, `full`=0, `rd_valid`=0, `rd_data`=0.
- Fill, wrap and drain (DEPTH=16):
  - Stimulus: write 0x1000_0000..0x1000_000F, then write 0xDEAD_BEEF.
  - Required: `full`=1 after 16 writes, `almost_full`=1 from level 12. The 17th write is rejected and `overflow`=1.
  - Then read 16 times. Required: data returns in order, each word one cycle after its `rd_en`, and `empty`=1 at the end.
  - Then write 20 words and read 20 words interleaved. Required: correct order across pointer wrap.
- Simultaneous access at full:
  - Stimulus: with level 16, assert `rd_en`=`wr_en`=1 and write 0xA5A5_A5A5.
  - Required: level stays 16, the oldest word is output, and 0xA5A5_A5A5 becomes the last entry.
- Simultaneous access at empty:
  - Stimulus: with level 0, assert `rd_en`=`wr_en`=1 and write 0x0000_0042.
  - Required: `rd_valid`=0, `underflow`=1, level=1. The next read returns 0x42.
- Error clear and priority:
  - Stimulus: with `overflow`=1, pulse `clr_err`. Required: `overflow`=0.
  - Stimulus: pulse `clr_err` in the same cycle as a write to a full FIFO. Required: `overflow` stays 1.
- Reset mid-transfer and DMA pattern:
  - Stimulus: assert `rst` at level 5. Required: `empty`=1 immediately.
  - Stimulus: drive `dma_fsm`-style alternating write/read for size 16, which gives 4 words. Required: `level` peaks at 1 and 4 `rd_valid` pulses occur.

Source files
------------

// File: rtl/dma_fifo.sv
// dma_fifo: single-clock word buffer between DMA fetch and deposit; read data one cycle after rd_en, writes at full accepted only alongside a read.
// Optional sticky overflow/underflow flags with clr_err are built when DMA_FIFO_ERR_EN is defined.
module dma_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level
`ifdef DMA_FIFO_ERR_EN
    ,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     underflow
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_rd_acc = rd_en & ~w_empty;
    // At full, a concurrent read frees the slot this write lands in.
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef DMA_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_ovf_set = wr_en & ~w_wr_acc;
    assign w_udf_set = rd_en & w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_level >= LW'(AF_THRESH));
    assign level       = r_level;

endmodule

// File: tb/tb_dma_fifo.sv
// Self-checking bench for dma_fifo: stimulus table for fill/overflow/drain plus scoreboarded corner-case sequences.
module tb_dma_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          clr_err;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [4:0]    level;
`ifdef DMA_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    always #5 clk = ~clk;

    dma_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level)
`ifdef DMA_FIFO_ERR_EN
        ,
        .clr_err     (clr_err),
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int            peak    = 0;
    int            vld_cnt = 0;
    logic [DW-1:0] model [$];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        bit            wr;
        bit            rd;
        logic [DW-1:0] d;
        int            lvl;
        bit            vld;
        logic [DW-1:0] rdat;
    } vec_t;
    vec_t tv [33];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the scoreboard predicts acceptance from the model's pre-edge occupancy.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bit            acc_r;
        bit            acc_w;
        logic [DW-1:0] e;
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        acc_r = r && (model.size() > 0);
        acc_w = w && ((model.size() < DEPTH) || acc_r);
        if (acc_r) exp_q.push_back(model.pop_front());
        if (acc_w) model.push_back(d);
        @(posedge clk);
        #1;
        chk("sb_rd_valid", {31'b0, rd_valid}, {31'b0, acc_r});
        if (acc_r && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_rd_data", rd_data, e);
        end
        chk("sb_level", {27'b0, level}, model.size());
        if (rd_valid) vld_cnt++;
        if (int'(level) > peak) peak = int'(level);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] last;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;

        // Reset then idle
        #13;
        chk("rst_empty", {31'b0, empty}, 1);
        chk("rst_level", {27'b0, level}, 0);
        chk("rst_full", {31'b0, full}, 0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0);
        chk("idle_empty", {31'b0, empty}, 1);
        chk("idle_af", {31'b0, almost_full}, 0);

        // Fill, overflow attempt, drain: table-driven
        for (int i = 0; i < 16; i++)
            tv[i] = '{wr: 1'b1, rd: 1'b0, d: 32'h1000_0000 + i, lvl: i + 1, vld: 1'b0, rdat: '0};
        tv[16] = '{wr: 1'b1, rd: 1'b0, d: 32'hDEAD_BEEF, lvl: 16, vld: 1'b0, rdat: '0};
        for (int k = 0; k < 16; k++)
            tv[17 + k] = '{wr: 1'b0, rd: 1'b1, d: '0, lvl: 15 - k, vld: 1'b1, rdat: 32'h1000_0000 + k};
        for (int i = 0; i < 33; i++) begin
            step(tv[i].wr, tv[i].d, tv[i].rd, 0);
            chk("tv_level", {27'b0, level}, tv[i].lvl);
            chk("tv_full", {31'b0, full}, (tv[i].lvl == DEPTH) ? 1 : 0);
            chk("tv_empty", {31'b0, empty}, (tv[i].lvl == 0) ? 1 : 0);
            chk("tv_almost_full", {31'b0, almost_full}, (tv[i].lvl >= AF) ? 1 : 0);
            chk("tv_rd_valid", {31'b0, rd_valid}, {31'b0, tv[i].vld});
            if (tv[i].vld) chk("tv_rd_data", rd_data, tv[i].rdat);
`ifdef DMA_FIFO_ERR_EN
            chk("tv_overflow", {31'b0, overflow}, (i >= 16) ? 1 : 0);
`endif
        end

        // Interleaved write/read across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1, 32'h2000_0000 + i, 0, 0);
            step(0, 0, 1, 0);
        end
        chk("wrap_empty", {31'b0, empty}, 1);

        // Simultaneous access at full
        for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0);
        chk("full_before", {31'b0, full}, 1);
        step(1, 32'hA5A5_A5A5, 1, 0);
        chk("simfull_level", {27'b0, level}, 16);
        chk("simfull_rd_valid", {31'b0, rd_valid}, 1);
        last = '0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0);
            last = rd_data;
        end
        chk("simfull_last_entry", last, 32'hA5A5_A5A5);
        chk("simfull_drained", {31'b0, empty}, 1);

        // Simultaneous access at empty
        step(1, 32'h0000_0042, 1, 0);
        chk("simempty_rd_valid", {31'b0, rd_valid}, 0);
        chk("simempty_level", {27'b0, level}, 1);
`ifdef DMA_FIFO_ERR_EN
        chk("simempty_underflow", {31'b0, underflow}, 1);
`endif
        step(0, 0, 1, 0);
        chk("simempty_next_read", rd_data, 32'h0000_0042);

        // Error clear and set-over-clear priority
`ifdef DMA_FIFO_ERR_EN
        chk("err_ovf_sticky", {31'b0, overflow}, 1);
        step(0, 0, 0, 1);
        chk("err_ovf_cleared", {31'b0, overflow}, 0);
        chk("err_udf_cleared", {31'b0, underflow}, 0);
`endif
        for (int i = 0; i < 16; i++) step(1, 32'h3000_0000 + i, 0, 0);
        step(1, 32'h0BAD_0BAD, 0, 1);
        chk("err_full_level", {27'b0, level}, 16);
`ifdef DMA_FIFO_ERR_EN
        chk("err_set_wins", {31'b0, overflow}, 1);
`endif
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);

        // Asynchronous reset mid-transfer at level 5
        for (int i = 0; i < 5; i++) step(1, 32'h4000_0000 + i, 0, 0);
        chk("pre_rst_level", {27'b0, level}, 5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_empty", {31'b0, empty}, 1);
        chk("async_rst_level", {27'b0, level}, 0);
        model.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // DMA-style alternating write/read, 4 words
        peak    = 0;
        vld_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h5000_0000 + i, 0, 0);
            step(0, 0, 1, 0);
        end
        chk("dma_peak_level", peak, 1);
        chk("dma_rd_valid_pulses", vld_cnt, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
